// File: rtl/split_accum32_if.sv
// Handshake bundle between the split accumulator and its upstream/downstream neighbours.
// The master drives burst control and words; the slave returns readiness and the total.
interface split_accum32_if #(
   parameter int LEN_W = 8
);
   logic             start;
   logic [LEN_W-1:0] len;
   logic             in_valid;
   logic [31:0]      in_data;
   logic             in_ready;
   logic             out_valid;
   logic [31:0]      out_sum;
   logic             out_ovf;
   logic             out_ready;
   logic             busy;

   modport master (
      output start, len, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf, busy
   );

   modport slave (
      input  start, len, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum, out_ovf, busy
   );
endinterface

// File: rtl/split_accum32.sv
// Burst accumulator that adds each 32-bit word as two 16-bit halves on consecutive
// cycles, carrying between the halves through c16 and flagging carry out of bit 31.
module split_accum32 #(
   parameter int LEN_W = 8
) (
   input  logic           clk,
   input  logic           reset,
   split_accum32_if.slave bus
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACC_LO = 2'd1;
   localparam logic [1:0] ACC_HI = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [31:0]      acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic             c16_q, c16_d;
   logic [15:0]      hi_q, hi_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;

   logic [16:0]      loSum;
   logic [16:0]      hiSum;

   assign loSum = {1'b0, acc_q[15:0]} + {1'b0, bus.in_data[15:0]};
   assign hiSum = {1'b0, acc_q[31:16]} + {1'b0, hi_q} + {16'b0, c16_q};

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      c16_d   = c16_q;
      hi_d    = hi_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               acc_d   = 32'd0;
               ovf_d   = 1'b0;
               c16_d   = 1'b0;
               cnt_d   = bus.len;
               state_d = (bus.len == '0) ? DONE : ACC_LO;
            end
         end
         ACC_LO: begin
            if (bus.in_valid) begin
               acc_d   = {acc_q[31:16], loSum[15:0]};
               c16_d   = loSum[16];
               hi_d    = bus.in_data[31:16];
               state_d = ACC_HI;
            end
         end
         ACC_HI: begin
            // Upper half closes the word; its carry is the true carry out of bit 31.
            acc_d   = {hiSum[15:0], acc_q[15:0]};
            ovf_d   = ovf_q | hiSum[16];
            cnt_d   = cnt_q - LEN_W'(1);
            state_d = (cnt_q == LEN_W'(1)) ? DONE : ACC_LO;
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= 32'd0;
         ovf_q   <= 1'b0;
         c16_q   <= 1'b0;
         hi_q    <= 16'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         c16_q   <= c16_d;
         hi_q    <= hi_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.in_ready  = (state_q == ACC_LO);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_sum   = acc_q;
   assign bus.out_ovf   = ovf_q;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_split_accum32.sv
// Directed and randomized bursts through split_accum32, checked against a
// whole-word arithmetic model of the burst total and overflow flag.
module tb_split_accum32;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checkCount = 0;
   int   errorCount = 0;

   logic [31:0] words[$];

   split_accum32_if #(.LEN_W(8)) bus ();

   split_accum32 #(.LEN_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected)
      else begin
         errorCount++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic reportTimeout(input string tag);
      checkCount++;
      errorCount++;
      $error("FAIL %s: observed timeout expected event", tag);
   endtask

   // Whole-word reference: running total in 64 bits, wrap at 2^32 and remember any wrap.
   task automatic referenceModel(output logic [31:0] expSum, output logic expOvf);
      longint unsigned run;
      run    = 0;
      expOvf = 1'b0;
      foreach (words[i]) begin
         run = run + longint'(words[i]);
         if (run >= 64'h1_0000_0000) begin
            expOvf = 1'b1;
            run    = run - 64'h1_0000_0000;
         end
      end
      expSum = run[31:0];
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic feedWord(input logic [31:0] data);
      bit seen;
      seen         = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = data;
      for (int k = 0; k < 8 && !seen; k++) begin
         if (bus.in_ready) seen = 1'b1;
         else stepCycle();
      end
      if (!seen) reportTimeout("inReadyWait");
      stepCycle();
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom;
      checkOutput("inReadyLowAfterAccept", {31'd0, bus.in_ready}, 32'd0);
   endtask

   task automatic applyStimulus(input int stall, input int holdReady, input bit pokeStart);
      logic [31:0] expSum;
      logic        expOvf;
      int          startCyc, n, lat;
      bit          seen;
      n = words.size();
      referenceModel(expSum, expOvf);
      bus.len   = 8'(n);
      bus.start = 1'b1;
      stepCycle();
      startCyc  = cyc;
      bus.start = 1'b0;
      bus.len   = 8'($urandom);
      checkOutput("busyAfterStart", {31'd0, bus.busy}, 32'd1);
      for (int i = 0; i < n; i++) begin
         for (int s = 0; s < stall; s++) begin
            bus.in_valid = 1'b0;
            bus.in_data  = $urandom;
            checkOutput("inReadyDuringStall", {31'd0, bus.in_ready}, (i > 0 && s == 0) ? 32'd0 : 32'd1);
            stepCycle();
         end
         feedWord(words[i]);
      end
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
         if (bus.out_valid) seen = 1'b1;
         else stepCycle();
      end
      if (!seen) begin
         reportTimeout("outValidWait");
         return;
      end
      lat = cyc - startCyc + 1;
      if (stall == 0) checkOutput("latency", lat, 2 * n + 1);
      checkOutput("outSum", bus.out_sum, expSum);
      checkOutput("outOvf", {31'd0, bus.out_ovf}, {31'd0, expOvf});
      bus.out_ready = 1'b0;
      for (int h = 0; h < holdReady; h++) begin
         if (pokeStart && h == 0) begin
            bus.start = 1'b1;
            bus.len   = 8'd3;
         end
         stepCycle();
         bus.start = 1'b0;
         checkOutput("holdValid", {31'd0, bus.out_valid}, 32'd1);
         checkOutput("holdSum", bus.out_sum, expSum);
         checkOutput("holdOvf", {31'd0, bus.out_ovf}, {31'd0, expOvf});
      end
      bus.out_ready = 1'b1;
      stepCycle();
      bus.out_ready = 1'b0;
      checkOutput("validAfterTake", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("busyAfterTake", {31'd0, bus.busy}, 32'd0);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "InReady"}, {31'd0, bus.in_ready}, 32'd0);
      checkOutput({tag, "OutValid"}, {31'd0, bus.out_valid}, 32'd0);
      checkOutput({tag, "Busy"}, {31'd0, bus.busy}, 32'd0);
      checkOutput({tag, "OutSum"}, bus.out_sum, 32'd0);
      checkOutput({tag, "OutOvf"}, {31'd0, bus.out_ovf}, 32'd0);
   endtask

   initial begin
      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.len       = 8'd0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 32'd0;
      bus.out_ready = 1'b0;
      stepCycle();
      stepCycle();
      checkResetValues("reset");
      reset = 1'b0;
      stepCycle();

      $display("[TB] basic sum");
      words = '{32'd1, 32'd2, 32'd3};
      applyStimulus(0, 0, 1'b0);

      $display("[TB] half-boundary carry");
      words = '{32'h0000_FFFF, 32'h0000_0001};
      applyStimulus(0, 1, 1'b0);

      $display("[TB] overflow wrap then clean burst");
      words = '{32'hFFFF_FFFF, 32'h0000_0002};
      applyStimulus(0, 0, 1'b0);
      words = '{32'd5};
      applyStimulus(0, 0, 1'b0);

      $display("[TB] zero length with backpressure and ignored start");
      words = {};
      applyStimulus(0, 5, 1'b1);

      $display("[TB] input stalls");
      words = '{32'h8000_0000, 32'h8000_0000};
      applyStimulus(3, 0, 1'b0);

      $display("[TB] reset mid-burst");
      bus.len   = 8'd4;
      bus.start = 1'b1;
      stepCycle();
      bus.start = 1'b0;
      feedWord(32'hAAAA_BBBB);
      feedWord(32'hCCCC_DDDD);
      reset = 1'b1;
      stepCycle();
      reset = 1'b0;
      checkResetValues("midReset");
      words = '{32'h1234_5678};
      applyStimulus(0, 0, 1'b0);

      $display("[TB] reset beats start");
      reset     = 1'b1;
      bus.start = 1'b1;
      bus.len   = 8'd3;
      stepCycle();
      reset     = 1'b0;
      bus.start = 1'b0;
      checkResetValues("resetStart");
      stepCycle();
      checkOutput("busyStaysIdle", {31'd0, bus.busy}, 32'd0);

      $display("[TB] random bursts");
      for (int r = 0; r < 8; r++) begin
         int n;
         n = $urandom_range(1, 6);
         words = {};
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) words.push_back({16'hFFFF, 16'($urandom)});
            else words.push_back($urandom);
         end
         bus.out_ready = 1'b1;
         applyStimulus($urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
